// File: rtl/blink_pkg.sv
// Shared mode encodings for the blink/PWM timer bank.
// The reserved mode code decodes to TOGGLE so stray writes still produce a sane indicator.
package blink_pkg;
  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_TOGGLE  = 2'd0,
    MODE_PWM     = 2'd1,
    MODE_ONESHOT = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_e;

  function automatic mode_e eff_mode(input logic [MODE_W-1:0] m);
    return (m == MODE_RSVD) ? MODE_TOGGLE : mode_e'(m);
  endfunction
endpackage

// File: rtl/blink_channel.sv
// One timer channel: config regs, tick counter, blink and wrap pulse, all registered.
// Config writes take effect at the write edge with no stall and override any same-edge wrap.
module blink_channel
  import blink_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              cfg_we,
  input  logic              cfg_enable,
  input  logic [MODE_W-1:0] cfg_mode,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [CNT_W-1:0]  cfg_duty,
  output logic              blink,
  output logic              wrap_pulse,
  output logic [CNT_W-1:0]  cnt
);
  logic             enable_q, enable_d;
  mode_e            mode_q, mode_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] duty_q, duty_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             blink_q, blink_d;
  logic             wrap_q, wrap_d;
  logic             wrap_now;

  always_comb begin
    enable_d = enable_q;
    mode_d   = mode_q;
    period_d = period_q;
    duty_d   = duty_q;
    cnt_d    = cnt_q;
    blink_d  = blink_q;
    wrap_d   = 1'b0;
    wrap_now = 1'b0;
    if (cfg_we) begin
      enable_d = cfg_enable;
      mode_d   = eff_mode(cfg_mode);
      period_d = cfg_period;
      duty_d   = cfg_duty;
      cnt_d    = '0;
      blink_d  = cfg_enable && (eff_mode(cfg_mode) == MODE_ONESHOT);
    end else if (enable_q) begin
      if (tick) begin
        if (cnt_q == period_q) begin
          cnt_d    = '0;
          wrap_now = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      wrap_d = wrap_now;
      case (mode_q)
        MODE_PWM: begin
          if (tick) blink_d = (cnt_d < duty_q);
        end
        MODE_ONESHOT: begin
          blink_d = 1'b1;
          if (wrap_now) begin
            blink_d  = 1'b0;
            enable_d = 1'b0;
          end
        end
        default: begin
          if (wrap_now) blink_d = ~blink_q;
        end
      endcase
    end else if (mode_q == MODE_PWM) begin
      blink_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enable_q <= 1'b0;
      mode_q   <= MODE_TOGGLE;
      period_q <= '0;
      duty_q   <= '0;
      cnt_q    <= '0;
      blink_q  <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      enable_q <= enable_d;
      mode_q   <= mode_d;
      period_q <= period_d;
      duty_q   <= duty_d;
      cnt_q    <= cnt_d;
      blink_q  <= blink_d;
      wrap_q   <= wrap_d;
    end
  end

  assign blink      = blink_q;
  assign wrap_pulse = wrap_q;
  assign cnt        = cnt_q;
endmodule

// File: rtl/blink_timer_bank.sv
// NUM_CH blink/PWM timers sharing one prescaler; outputs registered, config always accepted.
// Writes addressed beyond NUM_CH-1 match no channel and are dropped.
module blink_timer_bank
  import blink_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 8,
  parameter int PRESCALE_W = 4,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [PRESCALE_W-1:0]   prescale,
  input  logic                    cfg_valid,
  input  logic [CH_W-1:0]         cfg_ch,
  input  logic                    cfg_enable,
  input  logic [MODE_W-1:0]       cfg_mode,
  input  logic [CNT_W-1:0]        cfg_period,
  input  logic [CNT_W-1:0]        cfg_duty,
  output logic [NUM_CH-1:0]       blink,
  output logic [NUM_CH-1:0]       wrap_pulse,
  output logic [NUM_CH*CNT_W-1:0] count_flat
);
  logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
  logic                  tick;
  logic [NUM_CH-1:0]     cfg_we;

  // Equality compare: a prescale lowered below pcnt waits for the natural wrap.
  always_comb begin
    tick   = (pcnt_q == prescale);
    pcnt_d = tick ? '0 : pcnt_q + PRESCALE_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) pcnt_q <= '0;
    else       pcnt_q <= pcnt_d;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign cfg_we[i] = cfg_valid && (cfg_ch == CH_W'(i));

    blink_channel #(.CNT_W(CNT_W)) u_ch (
      .clk        (clk),
      .reset      (reset),
      .tick       (tick),
      .cfg_we     (cfg_we[i]),
      .cfg_enable (cfg_enable),
      .cfg_mode   (cfg_mode),
      .cfg_period (cfg_period),
      .cfg_duty   (cfg_duty),
      .blink      (blink[i]),
      .wrap_pulse (wrap_pulse[i]),
      .cnt        (count_flat[i*CNT_W +: CNT_W])
    );
  end
endmodule

// File: tb/tb_blink_timer_bank.sv
// Directed bench for blink_timer_bank: a cycle-by-cycle vector table plus hand sequences
// for PWM timing, ONESHOT self-clear and reset-with-write.
module tb_blink_timer_bank;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  prescale;
  logic        cfg_valid;
  logic [1:0]  cfg_ch;
  logic        cfg_enable;
  logic [1:0]  cfg_mode;
  logic [7:0]  cfg_period;
  logic [7:0]  cfg_duty;
  logic [3:0]  blink;
  logic [3:0]  wrap_pulse;
  logic [31:0] count_flat;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  blink_timer_bank dut (
    .clk        (clk),
    .reset      (reset),
    .prescale   (prescale),
    .cfg_valid  (cfg_valid),
    .cfg_ch     (cfg_ch),
    .cfg_enable (cfg_enable),
    .cfg_mode   (cfg_mode),
    .cfg_period (cfg_period),
    .cfg_duty   (cfg_duty),
    .blink      (blink),
    .wrap_pulse (wrap_pulse),
    .count_flat (count_flat)
  );

  typedef struct {
    logic        rst;
    logic        cv;
    logic [1:0]  ch;
    logic [1:0]  mode;
    logic [7:0]  per;
    logic [3:0]  eb;
    logic [3:0]  ew;
    logic [31:0] ec;
  } vec_t;

  localparam int NV = 38;
  vec_t vt [NV];

  function automatic vec_t mkv(logic rst, logic cv, logic [1:0] ch, logic [1:0] mode,
                               logic [7:0] per, logic [3:0] eb, logic [3:0] ew,
                               logic [31:0] ec);
    vec_t v;
    v.rst = rst; v.cv = cv; v.ch = ch; v.mode = mode; v.per = per;
    v.eb = eb; v.ew = ew; v.ec = ec;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cfg(input logic [1:0] ch, input logic en, input logic [1:0] mode,
                     input logic [7:0] per, input logic [7:0] duty);
    cfg_valid = 1'b1; cfg_ch = ch; cfg_enable = en;
    cfg_mode = mode; cfg_period = per; cfg_duty = duty;
  endtask

  initial begin
    int t;
    logic [9:0] e;

    // Rows 0-2 reset, 3-22 idle with all channels disabled.
    for (int i = 0; i < 3; i++) vt[i] = mkv(1, 0, 0, 0, 0, 4'h0, 4'h0, 32'h0);
    for (int i = 3; i < 23; i++) vt[i] = mkv(0, 0, 0, 0, 0, 4'h0, 4'h0, 32'h0);
    // ch0 TOGGLE period 3, tick every cycle.
    vt[23] = mkv(0, 1, 0, 0, 3, 4'h0, 4'h0, 32'h00000000);
    vt[24] = mkv(0, 0, 0, 0, 0, 4'h0, 4'h0, 32'h00000001);
    vt[25] = mkv(0, 0, 0, 0, 0, 4'h0, 4'h0, 32'h00000002);
    vt[26] = mkv(0, 0, 0, 0, 0, 4'h0, 4'h0, 32'h00000003);
    vt[27] = mkv(0, 0, 0, 0, 0, 4'h1, 4'h1, 32'h00000000);
    vt[28] = mkv(0, 0, 0, 0, 0, 4'h1, 4'h0, 32'h00000001);
    vt[29] = mkv(0, 0, 0, 0, 0, 4'h1, 4'h0, 32'h00000002);
    vt[30] = mkv(0, 0, 0, 0, 0, 4'h1, 4'h0, 32'h00000003);
    vt[31] = mkv(0, 0, 0, 0, 0, 4'h0, 4'h1, 32'h00000000);
    // ch3 TOGGLE period 1, then ch0 rewritten on the edge it would wrap.
    vt[32] = mkv(0, 1, 3, 0, 1, 4'h0, 4'h0, 32'h00000001);
    vt[33] = mkv(0, 0, 0, 0, 0, 4'h0, 4'h0, 32'h01000002);
    vt[34] = mkv(0, 0, 0, 0, 0, 4'h8, 4'h8, 32'h00000003);
    vt[35] = mkv(0, 1, 0, 0, 3, 4'h8, 4'h0, 32'h01000000);
    vt[36] = mkv(0, 0, 0, 0, 0, 4'h0, 4'h8, 32'h00000001);
    vt[37] = mkv(0, 0, 0, 0, 0, 4'h0, 4'h0, 32'h01000002);

    reset = 1'b1; prescale = 4'd0; cfg_valid = 1'b0; cfg_ch = 2'd0;
    cfg_enable = 1'b0; cfg_mode = 2'd0; cfg_period = 8'd0; cfg_duty = 8'd0;

    for (int i = 0; i < NV; i++) begin
      reset = vt[i].rst; cfg_valid = vt[i].cv; cfg_ch = vt[i].ch; cfg_enable = 1'b1;
      cfg_mode = vt[i].mode; cfg_period = vt[i].per; cfg_duty = 8'd0; prescale = 4'd0;
      step();
      chk($sformatf("vec%0d", i), {24'h0, blink, wrap_pulse, count_flat},
          {24'h0, vt[i].eb, vt[i].ew, vt[i].ec});
    end

    // PWM on ch1, prescale 2: pcnt is 0 at the write edge, so ticks land on k=2,5,8,...
    prescale = 4'd2;
    cfg(2'd1, 1'b1, 2'd1, 8'd9, 8'd3);
    for (int k = 0; k <= 90; k++) begin
      step();
      cfg_valid = 1'b0;
      t = (k + 1) / 3;
      e = {((t >= 1) && (t % 10 < 3)), (((k + 1) % 3 == 0) && (t >= 1) && (t % 10 == 0)),
           8'(t % 10)};
      chk($sformatf("pwm_d3_k%0d", k), {54'h0, blink[1], wrap_pulse[1], count_flat[15:8]},
          {54'h0, e});
    end

    cfg(2'd1, 1'b1, 2'd1, 8'd9, 8'd0);
    for (int k = 0; k <= 40; k++) begin
      step();
      cfg_valid = 1'b0;
      chk($sformatf("pwm_d0_k%0d", k), {63'h0, blink[1]}, 64'h0);
    end

    cfg(2'd1, 1'b1, 2'd1, 8'd9, 8'd12);
    for (int k = 0; k <= 40; k++) begin
      step();
      cfg_valid = 1'b0;
      if (k == 0) chk("pwm_d12_cfg", {63'h0, blink[1]}, 64'h0);
      else if (k >= 3) chk($sformatf("pwm_d12_k%0d", k), {63'h0, blink[1]}, 64'h1);
    end

    // Lowered prescale may wait for the pcnt wrap; let it settle before the ONESHOT.
    prescale = 4'd0;
    repeat (20) step();
    cfg(2'd2, 1'b1, 2'd2, 8'd5, 8'd0);
    for (int k = 0; k <= 14; k++) begin
      step();
      cfg_valid = 1'b0;
      e = {(k <= 5), (k == 6), ((k <= 5) ? 8'(k) : 8'd0)};
      chk($sformatf("oneshot_k%0d", k), {54'h0, blink[2], wrap_pulse[2], count_flat[23:16]},
          {54'h0, e});
    end

    reset = 1'b1;
    cfg(2'd2, 1'b1, 2'd2, 8'd5, 8'd0);
    step();
    chk("reset_with_cfg", {24'h0, blink, wrap_pulse, count_flat}, 64'h0);
    reset = 1'b0; cfg_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("post_reset_k%0d", k), {24'h0, blink, wrap_pulse, count_flat}, 64'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
